// File: rtl/truth_table_sweeper.sv
// Purpose : drives codes 0..15 into a 4-input function unit, captures F per code, checks it against EXPECTED.
// Latency : done pulses 16*(SETTLE_CYCLES+1) cycles after the start-accept edge; all outputs registered.
// Backpr. : none; start is accepted only in IDLE, abort cancels a sweep, results hold until the next start/abort/rst.
// Ports   : clk, rst (sync, active-high); start/abort control; abcd_out -> unit, f_in <- unit;
//           busy/done status; table_out, match, mismatch_count, first_fail(_valid) results.
`timescale 1ns/1ps
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 0,
  parameter logic [15:0] EXPECTED      = 16'hDF03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  abcd_out,
  input  logic        f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        match,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail,
  output logic        first_fail_valid
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_abcd,  w_abcd_nxt;
  logic [3:0]  r_cnt,   w_cnt_nxt;
  logic        r_busy,  w_busy_nxt;
  logic        r_done,  w_done_nxt;
  logic [15:0] r_table, w_table_nxt;
  logic        r_match, w_match_nxt;
  logic [4:0]  r_mcnt,  w_mcnt_nxt;
  logic [3:0]  r_ff,    w_ff_nxt;
  logic        r_ffv,   w_ffv_nxt;
  logic        w_miss;

  assign w_miss = f_in ^ EXPECTED[r_abcd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_abcd  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_table <= '0;
      r_match <= 1'b0;
      r_mcnt  <= '0;
      r_ff    <= '0;
      r_ffv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_abcd  <= w_abcd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_table <= w_table_nxt;
      r_match <= w_match_nxt;
      r_mcnt  <= w_mcnt_nxt;
      r_ff    <= w_ff_nxt;
      r_ffv   <= w_ffv_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_abcd_nxt  = r_abcd;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_table_nxt = r_table;
    w_match_nxt = r_match;
    w_mcnt_nxt  = r_mcnt;
    w_ff_nxt    = r_ff;
    w_ffv_nxt   = r_ffv;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SWEEP;
          w_busy_nxt  = 1'b1;
          w_abcd_nxt  = '0;
          w_cnt_nxt   = '0;
          w_table_nxt = '0;
          w_match_nxt = 1'b0;
          w_mcnt_nxt  = '0;
          w_ff_nxt    = '0;
          w_ffv_nxt   = 1'b0;
        end
      end
      S_SWEEP: begin
        if (abort) begin
          // Abort wins over a sample on the same edge and wipes all results.
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_abcd_nxt  = '0;
          w_cnt_nxt   = '0;
          w_table_nxt = '0;
          w_match_nxt = 1'b0;
          w_mcnt_nxt  = '0;
          w_ff_nxt    = '0;
          w_ffv_nxt   = 1'b0;
        end else if (r_cnt != SETTLE) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else begin
          w_table_nxt[r_abcd] = f_in;
          if (w_miss) begin
            w_mcnt_nxt = r_mcnt + 5'd1;
            if (!r_ffv) begin
              w_ff_nxt  = r_abcd;
              w_ffv_nxt = 1'b1;
            end
          end
          w_cnt_nxt = '0;
          if (r_abcd == 4'd15) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_abcd_nxt  = '0;
            // Compare the table including the sample taken on this edge.
            w_match_nxt = (w_table_nxt == EXPECTED);
          end else begin
            w_abcd_nxt = r_abcd + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign abcd_out         = r_abcd;
  assign busy             = r_busy;
  assign done             = r_done;
  assign table_out        = r_table;
  assign match            = r_match;
  assign mismatch_count   = r_mcnt;
  assign first_fail       = r_ff;
  assign first_fail_valid = r_ffv;

endmodule

// File: tb/tb_truth_table_sweeper.sv
`timescale 1ns/1ps
module tb_truth_table_sweeper;

  localparam logic [15:0] EXP_MASK = 16'hDF03;

  typedef struct packed {
    logic [15:0] tbl;
    logic        match;
    logic [4:0]  mcnt;
    logic [3:0]  ff;
    logic        ffv;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, abort = 1'b0, start0 = 1'b0, start2 = 1'b0;
  logic [3:0] abcd0, abcd2, ff0, ff2;
  logic f0, f2, busy0, busy2, done0, done2, match0, match2, ffv0, ffv2;
  logic [15:0] tbl0, tbl2;
  logic [4:0] mcnt0, mcnt2;
  int mode0 = 0, mode2 = 4;   // 0 ok, 1 stuck-0, 2 inverted, 3 fault@13, 4 two-stage pipeline
  logic p0a, p0b, p2a, p2b;

  int n_checks = 0, n_fail = 0;
  res_t sb[$];

  truth_table_sweeper dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .abcd_out(abcd0), .f_in(f0),
    .busy(busy0), .done(done0), .table_out(tbl0), .match(match0), .mismatch_count(mcnt0),
    .first_fail(ff0), .first_fail_valid(ffv0)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(16'hDF03)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .abcd_out(abcd2), .f_in(f2),
    .busy(busy2), .done(done2), .table_out(tbl2), .match(match2), .mismatch_count(mcnt2),
    .first_fail(ff2), .first_fail_valid(ffv2)
  );

  // Reference F = sum m(0,1,8,9,10,11,12,14,15) written as sum of products.
  function automatic logic f_ref(input logic [3:0] c);
    logic a, b, cc, d;
    {a, b, cc, d} = c;
    return (~a & ~b & ~cc) | (a & ~b) | (a & b & ~d) | (a & b & cc);
  endfunction

  function automatic logic unit_comb(input int mode, input logic [3:0] c);
    case (mode)
      1:       return 1'b0;
      2:       return ~f_ref(c);
      3:       return f_ref(c) | (c == 4'd13);
      default: return f_ref(c);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    p0a <= f_ref(abcd0); p0b <= p0a;
    p2a <= f_ref(abcd2); p2b <= p2a;
  end

  always_comb begin
    f0 = (mode0 == 4) ? p0b : unit_comb(mode0, abcd0);
    f2 = (mode2 == 4) ? p2b : unit_comb(mode2, abcd2);
  end

  // Pipeline with too little settle time sees the code from two samples back
  // (code 0 before the sweep, since abcd idles at 0).
  function automatic res_t predict(input int mode, input int settle);
    res_t r;
    logic [15:0] diff;
    int seen;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      seen = i;
      if (mode == 4 && settle < 2) seen = (i >= 2) ? i - 2 : 0;
      r.tbl[i] = unit_comb((mode == 4) ? 0 : mode, 4'(seen));
    end
    diff    = r.tbl ^ EXP_MASK;
    r.match = (diff == 16'h0);
    r.mcnt  = 5'($countones(diff));
    r.ffv   = |diff;
    for (int i = 15; i >= 0; i--) if (diff[i]) r.ff = 4'(i);
    return r;
  endfunction

  // {abcd[32:29], busy[28], done[27], table[26:11], match[10], mcnt[9:5], ff[4:1], ffv[0]}
  function automatic logic [32:0] outs(input int sel);
    if (sel == 0) return {abcd0, busy0, done0, tbl0, match0, mcnt0, ff0, ffv0};
    return {abcd2, busy2, done2, tbl2, match2, mcnt2, ff2, ffv2};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v; else start2 = v;
  endtask

  task automatic launch(input int sel, input int mode, input int settle);
    sb.push_back(predict(mode, settle));
    set_start(sel, 1'b1);
  endtask

  task automatic run(input int sel, input int lat, input int restart_at, input bit chk_abcd, input bit chain);
    logic [32:0] o;
    res_t e;
    bit seen;
    int per;
    per = lat / 16;
    tick();
    set_start(sel, 1'b0);
    o = outs(sel);
    check_eq("busy_after_accept", o[28], 1);
    check_eq("abcd_after_accept", o[32:29], 0);
    seen = 0;
    for (int n = 1; n <= lat + 8 && !seen; n++) begin
      tick();
      if (restart_at != 0 && n == restart_at) set_start(sel, 1'b1);
      if (restart_at != 0 && n == restart_at + 1) set_start(sel, 1'b0);
      o = outs(sel);
      if (chk_abcd && n < lat) check_eq("abcd_step", o[32:29], n / per);
      if (o[27]) begin
        seen = 1;
        check_eq("done_latency", n, lat);
        check_eq("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq("busy_at_done", o[28], 0);
          check_eq("abcd_at_done", o[32:29], 0);
          check_eq("table_out", o[26:11], e.tbl);
          check_eq("match", o[10], e.match);
          check_eq("mismatch_count", o[9:5], e.mcnt);
          check_eq("first_fail", o[4:1], e.ff);
          check_eq("first_fail_valid", o[0], e.ffv);
        end
        if (chain) launch(sel, (sel == 0) ? mode0 : mode2, (sel == 0) ? 0 : 2);
      end
    end
    check_eq("done_seen", seen, 1);
  endtask

  initial begin
    int dcnt;
    bit hit;
    repeat (3) tick();
    check_eq("reset_dut0", outs(0), 0);
    check_eq("reset_dut2", outs(2), 0);
    rst = 1'b0;
    repeat (3) tick();

    // Correct unit, default settle; then results must hold in IDLE.
    mode0 = 0; launch(0, 0, 0); run(0, 16, 0, 1, 0);
    repeat (3) tick();
    check_eq("hold_table", tbl0, EXP_MASK);
    check_eq("hold_match", match0, 1);

    mode0 = 1; launch(0, 1, 0); run(0, 16, 0, 0, 0); repeat (3) tick();
    mode0 = 2; launch(0, 2, 0); run(0, 16, 0, 0, 0); repeat (3) tick();
    mode0 = 3; launch(0, 3, 0); run(0, 16, 0, 0, 0); repeat (3) tick();

    // Two-stage pipeline: enough settle on dut2, too little on dut0.
    mode2 = 4; launch(2, 4, 2); run(2, 48, 0, 1, 0); repeat (3) tick();
    mode0 = 4; launch(0, 4, 0); run(0, 16, 0, 0, 0); repeat (3) tick();

    // start re-pulsed mid-sweep is ignored.
    mode0 = 0; launch(0, 0, 0); run(0, 16, 5, 0, 0); repeat (3) tick();

    // Abort at cycle 7 of a sweep.
    mode0 = 2; set_start(0, 1'b1); tick(); set_start(0, 1'b0);
    repeat (6) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check_eq("abort_outputs", outs(0), 0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (done0) dcnt++; end
    check_eq("abort_no_done", dcnt, 0);
    check_eq("abort_results_hold", outs(0), 0);

    // Synchronous reset mid-sweep at code 9.
    mode0 = 3; set_start(0, 1'b1); tick(); set_start(0, 1'b0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (abcd0 == 4'd9) hit = 1; else tick();
    end
    check_eq("reached_code9", hit, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("rst_mid_dut0", outs(0), 0);
    check_eq("rst_mid_dut2", outs(2), 0);
    repeat (3) tick();

    // start asserted during the done cycle starts a back-to-back sweep.
    mode0 = 0; launch(0, 0, 0); run(0, 16, 0, 0, 1); run(0, 16, 0, 0, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
